// File: rtl/apb_wait_completer.sv
// apb_wait_completer
//   APB completer with a word-addressed backing store, a fixed number of
//   wait states per access phase and PSLVERR generation for out-of-range
//   and read-only-region accesses.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   psel     completer select
//   penable  access-phase qualifier
//   pwrite   1 = write, 0 = read
//   paddr    byte address; word index = paddr[ADDR_W-1:log2(DATA_W/8)]
//   pwdata   write data
//   pstrb    byte write strobes
//   prdata   read data, valid with pready on a read; holds between transfers
//   pready   transfer completes this cycle (registered)
//   pslverr  error response, only ever high together with pready
module apb_wait_completer #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned RO_BASE     = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic [DATA_W-1:0]     pwdata,
    input  logic [DATA_W/8-1:0]   pstrb,
    output logic [DATA_W-1:0]     prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int unsigned NB     = DATA_W / 8;
    localparam int unsigned LSB    = (NB > 1) ? $clog2(NB) : 0;
    localparam int unsigned IDX_W  = ADDR_W - LSB;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit          NO_WAIT = (WAIT_CYCLES == 0);

    if (WAIT_CYCLES > 15) begin : g_chk_wait
        $error("apb_wait_completer: WAIT_CYCLES must be 0..15");
    end
    if (64'(DEPTH) > (64'd1 << IDX_W)) begin : g_chk_depth
        $error("apb_wait_completer: DEPTH exceeds the word-index range of paddr");
    end
    if (DATA_W % 8 != 0) begin : g_chk_dw
        $error("apb_wait_completer: DATA_W must be a multiple of 8");
    end

    // Byte-offset bits of paddr select nothing in a word-addressed store.
    if (LSB > 0) begin : g_unused_lsb
        logic unused_lsb;
        assign unused_lsb = ^paddr[LSB-1:0];
    end

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [MEM_AW-1:0]   widx_q;
    logic                wr_q;
    logic                err_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NB-1:0]       strb_q;
    logic [DATA_W-1:0]   prdata_q, prdata_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic [IDX_W-1:0]    idx_in;
    logic                oob_in;
    logic                err_in;
    logic                capture;
    logic                commit;
    logic [DATA_W-1:0]   wmask;

    assign idx_in = paddr[ADDR_W-1:LSB];
    assign oob_in = 32'(idx_in) >= DEPTH;
    assign err_in = oob_in | (pwrite & (32'(idx_in) >= RO_BASE));

    for (genvar b = 0; b < NB; b++) begin : g_mask
        assign wmask[8*b +: 8] = {8{strb_q[b]}};
    end

    // The setup-phase capture happens on the edge that ends the bus setup
    // cycle (IDLE exit), so the registered pready can already be high in the
    // first access cycle when WAIT_CYCLES is 0.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = prdata_q;
        capture   = 1'b0;
        commit    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (psel && !penable) begin
                    capture   = 1'b1;
                    state_d   = S_ACCESS;
                    cnt_d     = 4'(WAIT_CYCLES);
                    pready_d  = NO_WAIT;
                    pslverr_d = NO_WAIT & err_in;
                    if (!pwrite) begin
                        prdata_d = oob_in ? '0 : mem_q[idx_in[MEM_AW-1:0]];
                    end
                end
            end
            S_ACCESS: begin
                if (!psel) begin
                    state_d = S_IDLE;           // aborted: no write, no pready
                end else if (pready_q) begin
                    state_d = S_IDLE;
                    commit  = wr_q & ~err_q;
                end else begin
                    cnt_d     = cnt_q - 4'd1;
                    pready_d  = (cnt_q == 4'd1);
                    pslverr_d = (cnt_q == 4'd1) & err_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            widx_q    <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            if (capture) begin
                widx_q  <= idx_in[MEM_AW-1:0];
                wr_q    <= pwrite;
                err_q   <= err_in;
                wdata_q <= pwdata;
                strb_q  <= pstrb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else if (commit) begin
            mem_q[widx_q] <= (mem_q[widx_q] & ~wmask) | (wdata_q & wmask);
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_wait_completer.sv
// Testbench for apb_wait_completer. Two instances share one bus:
//   dut 0: default parameters (ADDR_W=8, WAIT_CYCLES=2)
//   dut 1: ADDR_W=9, WAIT_CYCLES=0 (out-of-range index and zero-wait paths)
// Each has its own psel. A word-array reference model predicts latency,
// error response, read data and store contents.
module tb_apb_wait_completer;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel_a, psel_b;
    logic        penable, pwrite;
    logic [8:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata_a, prdata_b;
    logic        pready_a, pready_b, pslverr_a, pslverr_b;

    always #5 clk = ~clk;

    apb_wait_completer u_dut_a (
        .clk     (clk),
        .rst     (rst),
        .psel    (psel_a),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr[7:0]),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .prdata  (prdata_a),
        .pready  (pready_a),
        .pslverr (pslverr_a)
    );

    apb_wait_completer #(
        .ADDR_W      (9),
        .WAIT_CYCLES (0)
    ) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .psel    (psel_b),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .prdata  (prdata_b),
        .pready  (pready_b),
        .pslverr (pslverr_b)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [31:0] mdl_mem  [2][64];
    logic [31:0] mdl_last [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic get_rdy(input int d);
        return (d == 0) ? pready_a : pready_b;
    endfunction

    function automatic logic get_err(input int d);
        return (d == 0) ? pslverr_a : pslverr_b;
    endfunction

    function automatic logic [31:0] get_rd(input int d);
        return (d == 0) ? prdata_a : prdata_b;
    endfunction

    task automatic set_sel(input int d, input logic v);
        psel_a = (d == 0) & v;
        psel_b = (d == 1) & v;
    endtask

    task automatic mdl_reset();
        for (int d = 0; d < 2; d++) begin
            mdl_last[d] = '0;
            for (int i = 0; i < 64; i++) mdl_mem[d][i] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_sel(0, 1'b0);
        penable = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mdl_reset();
    endtask

    task automatic idle(input int n);
        set_sel(0, 1'b0);
        penable = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check("idle_pready", {30'd0, pready_a, pready_b}, 32'd0);
            @(posedge clk); #1;
        end
    endtask

    // One complete transfer; entered and left at posedge+1.
    task automatic xfer(input int d, input logic wr, input logic [8:0] addr,
                        input logic [31:0] wd, input logic [3:0] st, input bit scramble);
        int unsigned idx, lat, exp_lat;
        logic        err;
        idx     = (d == 0) ? int'(addr[7:2]) : int'(addr[8:2]);
        exp_lat = (d == 0) ? 3 : 1;
        err     = (idx >= 64) || (wr && idx >= 48);

        set_sel(d, 1'b1);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wd;
        pstrb   = st;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (get_rdy(d) || lat >= 20) break;
            check("pslverr_while_waiting", {31'd0, get_err(d)}, 32'd0);
            @(posedge clk); #1;
            if (scramble) begin
                paddr  = 9'($urandom);
                pwdata = $urandom;
                pstrb  = 4'($urandom);
                pwrite = 1'($urandom);
            end
        end
        check("latency", lat, exp_lat);
        check("pready", {31'd0, get_rdy(d)}, 32'd1);
        check("pslverr", {31'd0, get_err(d)}, {31'd0, err});
        if (!wr) mdl_last[d] = err ? 32'd0 : mdl_mem[d][idx];
        check("prdata", get_rd(d), mdl_last[d]);
        if (wr && !err) begin
            for (int b = 0; b < 4; b++)
                if (st[b]) mdl_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
        end
        @(posedge clk); #1;
        set_sel(d, 1'b0);
        penable = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        pwrite = 1'b0;
        paddr  = '0;
        pwdata = '0;
        pstrb  = '0;
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_pready", {30'd0, pready_a, pready_b}, 32'd0);
        check("rst_pslverr", {30'd0, pslverr_a, pslverr_b}, 32'd0);
        check("rst_prdata_a", prdata_a, 32'd0);
        check("rst_prdata_b", prdata_b, 32'd0);
        @(posedge clk); #1;

        // Full write, read back, partial-strobe write, read back
        xfer(0, 1'b1, 9'h010, 32'hDEADBEEF, 4'hF, 1'b0);
        xfer(0, 1'b0, 9'h010, 32'h0, 4'h0, 1'b0);
        check("rd_deadbeef", mdl_last[0], 32'hDEADBEEF);
        xfer(0, 1'b1, 9'h010, 32'h0000AA00, 4'b0010, 1'b0);
        xfer(0, 1'b0, 9'h010, 32'h0, 4'h0, 1'b0);
        check("rd_deadaaef", mdl_last[0], 32'hDEADAAEF);

        // pstrb=0 write is a legal no-op
        xfer(0, 1'b1, 9'h010, 32'h11111111, 4'h0, 1'b0);
        xfer(0, 1'b0, 9'h010, 32'h0, 4'h0, 1'b0);

        // Read-only region and out-of-range index
        xfer(0, 1'b1, 9'h0C4, 32'hCAFEF00D, 4'hF, 1'b0);
        xfer(0, 1'b0, 9'h0C4, 32'h0, 4'h0, 1'b0);
        xfer(0, 1'b1, 9'h0BC, 32'h5A5A5A5A, 4'hF, 1'b0);   // index 47, last writable
        xfer(0, 1'b0, 9'h0BC, 32'h0, 4'h0, 1'b0);
        xfer(1, 1'b0, 9'h100, 32'h0, 4'h0, 1'b0);
        xfer(1, 1'b1, 9'h100, 32'h12345678, 4'hF, 1'b0);

        // Zero-wait back-to-back write/read, no idle cycle
        xfer(1, 1'b1, 9'h004, 32'hA5C3_0F96, 4'hF, 1'b0);
        xfer(1, 1'b0, 9'h004, 32'h0, 4'h0, 1'b0);
        idle(1);

        // Reset during the first wait cycle of a write
        xfer(0, 1'b1, 9'h008, 32'h0BADF00D, 4'hF, 1'b0);   // prior content
        set_sel(0, 1'b1);
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 9'h008;
        pwdata  = 32'h77777777;
        pstrb   = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        set_sel(0, 1'b0);
        penable = 1'b0;
        mdl_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_abort_pready", {31'd0, pready_a}, 32'd0);
            @(posedge clk); #1;
        end
        xfer(0, 1'b0, 9'h008, 32'h0, 4'h0, 1'b0);

        // penable without setup, then psel dropped during waits
        xfer(0, 1'b1, 9'h024, 32'h24242424, 4'hF, 1'b0);
        set_sel(0, 1'b1);
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 9'h020;
        pwdata  = 32'hFFFFFFFF;
        pstrb   = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_setup_pready", {31'd0, pready_a}, 32'd0);
            @(posedge clk); #1;
        end
        set_sel(0, 1'b0);
        penable = 1'b0;
        @(posedge clk); #1;
        set_sel(0, 1'b1);
        paddr  = 9'h024;
        pwdata = 32'hEEEEEEEE;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        set_sel(0, 1'b0);
        penable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_pready", {31'd0, pready_a}, 32'd0);
            @(posedge clk); #1;
        end
        xfer(0, 1'b0, 9'h020, 32'h0, 4'h0, 1'b0);
        xfer(0, 1'b0, 9'h024, 32'h0, 4'h0, 1'b0);

        // Randomized traffic with bus scrambling during waits
        for (int n = 0; n < 80; n++) begin
            int          d;
            logic [8:0]  a;
            d = int'($urandom_range(0, 1));
            a = 9'($urandom);
            if (d == 0) a[8] = 1'b0;
            xfer(d, 1'($urandom), a, $urandom, 4'($urandom), 1'b1);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
        end
        for (int i = 0; i < 64; i++) begin
            xfer(0, 1'b0, 9'(i * 4), 32'h0, 4'h0, 1'b0);
            xfer(1, 1'b0, 9'(i * 4), 32'h0, 4'h0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
